// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : snoop_bus_arbiter
// Purpose  : Round-robin arbiter and sequencer for the shared MSI snooping
//            bus. Grants one cache and broadcasts its coherence message. If
//            another snooper holds the block MODIFIED, it sequences that
//            snooper's writeback before releasing the bus.
// Options  : SNOOP_TIMEOUT_EN - adds a writeback watchdog that forces
//            RELEASE after TIMEOUT_CYCLES writeback cycles.
// Revision : 1.0 - initial release
// ============================================================================
module snoop_bus_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic [N_REQ-1:0]          i_Req,
  input  logic [2*N_REQ-1:0]        i_Message,
  input  logic [ADDR_W*N_REQ-1:0]   i_Addr,
  input  logic [N_REQ-1:0]          i_WbReq,
  input  logic                      i_WbDone,
  output logic [N_REQ-1:0]          o_Grant,
  output logic                      o_BusValid,
  output logic [1:0]                o_BusMessage,
  output logic [ADDR_W-1:0]         o_BusAddr,
  output logic [$clog2(N_REQ)-1:0]  o_BusOwner,
  output logic [N_REQ-1:0]          o_WbGrant,
  output logic                      o_Timeout
);

  localparam int OWN_W = $clog2(N_REQ);

  // Elaboration-time parameter range checks
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("snoop_bus_arbiter: N_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("snoop_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_BROADCAST = 3'd2,
    ST_SNOOP     = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_RELEASE   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [OWN_W-1:0]     ptr_q;
  logic [OWN_W-1:0]     owner_q;
  logic [1:0]           msg_q;
  logic [ADDR_W-1:0]    addr_q;

  logic [N_REQ-1:0]     grant_q;
  logic                 busvalid_q;
  logic [1:0]           busmsg_q;
  logic [ADDR_W-1:0]    busaddr_q;
  logic [OWN_W-1:0]     busowner_q;
  logic [N_REQ-1:0]     wbgrant_q;

  logic [N_REQ-1:0]     elig;
  logic                 hit;
  logic [OWN_W-1:0]     hit_idx;
  logic [1:0]           hit_msg;
  logic [ADDR_W-1:0]    hit_addr;
  logic [N_REQ-1:0]     owner_oh;
  logic [N_REQ-1:0]     wb_masked;
  logic [N_REQ-1:0]     wb_sel;
  logic [OWN_W-1:0]     ptr_next;

  // A requester counts only when it asserts i_Req with a non-zero message
  for (genvar k = 0; k < N_REQ; k++) begin : g_elig
    assign elig[k] = i_Req[k] && (i_Message[2*k+1:2*k] != 2'd0);
  end

  // Round-robin search from ptr_q upward; first eligible requester wins
  always_comb begin
    int j;
    hit      = 1'b0;
    hit_idx  = '0;
    hit_msg  = 2'd0;
    hit_addr = '0;
    j        = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr_q) + i) % N_REQ;
      if (!hit && elig[j]) begin
        hit      = 1'b1;
        hit_idx  = OWN_W'(j);
        hit_msg  = i_Message[2*j +: 2];
        hit_addr = i_Addr[ADDR_W*j +: ADDR_W];
      end
    end
  end

  // Owner one-hot, owner-masked writeback requests and lowest-index pick
  assign owner_oh  = N_REQ'(1) << owner_q;
  assign wb_masked = i_WbReq & ~owner_oh;
  assign wb_sel    = wb_masked & (~wb_masked + N_REQ'(1));
  assign ptr_next  = (owner_q == OWN_W'(N_REQ-1)) ? '0 : owner_q + OWN_W'(1);

`ifdef SNOOP_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_hit;

  // Watchdog counts writeback cycles without i_WbDone; cleared outside WRITEBACK
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      to_cnt_q <= '0;
    end else if (state_q != ST_WRITEBACK) begin
      to_cnt_q <= '0;
    end else if (!i_WbDone) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  assign timeout_hit = (state_q == ST_WRITEBACK) && !i_WbDone &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES-1));
  assign o_Timeout   = timeout_hit;
`else
  assign o_Timeout = 1'b0;
`endif

  // Next-state logic for the bus transaction sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (hit) state_d = ST_GRANT;
      ST_GRANT:     state_d = ST_BROADCAST;
      ST_BROADCAST: state_d = ST_SNOOP;
      ST_SNOOP:     state_d = (|wb_masked) ? ST_WRITEBACK : ST_RELEASE;
      ST_WRITEBACK: begin
        if (i_WbDone) state_d = ST_RELEASE;
`ifdef SNOOP_TIMEOUT_EN
        else if (timeout_hit) state_d = ST_RELEASE;
`endif
      end
      ST_RELEASE:   state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State register, request latch, round-robin pointer and registered outputs
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      msg_q      <= 2'd0;
      addr_q     <= '0;
      grant_q    <= '0;
      busvalid_q <= 1'b0;
      busmsg_q   <= 2'd0;
      busaddr_q  <= '0;
      busowner_q <= '0;
      wbgrant_q  <= '0;
    end else begin
      state_q    <= state_d;
      busvalid_q <= (state_q == ST_BROADCAST);

      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            owner_q <= hit_idx;
            msg_q   <= hit_msg;
            addr_q  <= hit_addr;
          end
        end
        ST_GRANT: begin
          grant_q    <= owner_oh;
          busowner_q <= owner_q;
          busmsg_q   <= msg_q;
          busaddr_q  <= addr_q;
        end
        ST_SNOOP: begin
          if (|wb_masked) wbgrant_q <= wb_sel;
        end
        ST_RELEASE: begin
          ptr_q <= ptr_next;
        end
        default: ;
      endcase

      // Bus is visibly free for the whole RELEASE cycle
      if (state_d == ST_RELEASE) begin
        grant_q    <= '0;
        wbgrant_q  <= '0;
        busowner_q <= '0;
        busmsg_q   <= 2'd0;
        busaddr_q  <= '0;
      end
    end
  end

  assign o_Grant      = grant_q;
  assign o_BusValid   = busvalid_q;
  assign o_BusMessage = busmsg_q;
  assign o_BusAddr    = busaddr_q;
  assign o_BusOwner   = busowner_q;
  assign o_WbGrant    = wbgrant_q;

endmodule
`default_nettype wire
